// File: rtl/ascii_pkg.sv
// Shared constants, state encoding and bitmap row extraction for the ASCII glyph serializer.
package ascii_pkg;

    localparam int GLYPH_W    = 16;
    localparam int GLYPH_H    = 16;
    localparam int GLYPH_BITS = 256;

    localparam logic [11:0] DEFAULT_FG_COLOR = 12'hFFF;
    localparam logic [11:0] DEFAULT_BG_COLOR = 12'h000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CAP   = 2'd2,
        SHIFT = 2'd3
    } state_t;

    // Row 0 sits in the top 16 bits of the bitmap, so shift the wanted row down to bit 0.
    function automatic logic [GLYPH_W-1:0] row_slice(input logic [GLYPH_BITS-1:0] bitmap,
                                                     input logic [3:0]            row);
        logic [GLYPH_BITS-1:0] shifted;
        shifted   = bitmap >> {4'd15 - row, 4'b0000};
        row_slice = shifted[GLYPH_W-1:0];
    endfunction

endpackage

// File: rtl/ascii_glyph_serializer.sv
// Fetches one glyph row from the ROM and streams it as colour pixels with valid/ready.
// Optional build macro ASCII_GLYPH_DOUBLE_WIDTH_EN emits every glyph bit twice (32 pixels per row).
module ascii_glyph_serializer
    import ascii_pkg::*;
#(
    parameter int               PIX_W    = 12,
    parameter logic [PIX_W-1:0] FG_COLOR = 12'hFFF,
    parameter logic [PIX_W-1:0] BG_COLOR = 12'h000,
    parameter int               ROM_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  glyph_valid,
    output logic                  glyph_ready,
    input  logic [3:0]            glyph_idx,
    input  logic [3:0]            glyph_row,
    output logic [3:0]            rom_addr,
    input  logic [GLYPH_BITS-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [PIX_W-1:0]      pix_data,
    output logic                  pix_last
);

`ifdef ASCII_GLYPH_DOUBLE_WIDTH_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       WAIT_INIT = 2'(ROM_LAT);

    state_t               state_r, state_s;
    logic [1:0]           wait_cnt_r, wait_cnt_s;
    logic [3:0]           row_r, row_s;
    logic [3:0]           rom_addr_r, rom_addr_s;
    logic [GLYPH_W-1:0]   shreg_r, shreg_s, shreg_nx_s, slice_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 pix_valid_r, pix_valid_s;
    logic [PIX_W-1:0]     pix_data_r, pix_data_s;
    logic                 pix_last_r, pix_last_s;
    logic                 glyph_ready_r, glyph_ready_s;
    logic                 shift_en_s;

    // In double-width mode a bit is held for an even/odd pair of handshakes.
`ifdef ASCII_GLYPH_DOUBLE_WIDTH_EN
    assign shift_en_s = cnt_r[0];
`else
    assign shift_en_s = 1'b1;
`endif

    assign slice_s = row_slice(rom_data, row_r);

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        row_s       = row_r;
        rom_addr_s  = rom_addr_r;
        shreg_s     = shreg_r;
        shreg_nx_s  = shreg_r;
        cnt_s       = cnt_r;
        pix_valid_s = pix_valid_r;
        pix_data_s  = pix_data_r;
        pix_last_s  = pix_last_r;
        case (state_r)
            IDLE: begin
                if (glyph_valid) begin
                    rom_addr_s = glyph_idx;
                    row_s      = glyph_row;
                    wait_cnt_s = WAIT_INIT;
                    state_s    = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                wait_cnt_s = wait_cnt_r - 2'd1;
                if (wait_cnt_r <= 2'd1) begin
                    state_s = CAP;
                end else begin
                    state_s = WAIT;
                end
            end
            CAP: begin
                shreg_s     = slice_s;
                cnt_s       = {CNT_W{1'b0}};
                pix_valid_s = 1'b1;
                pix_data_s  = slice_s[GLYPH_W-1] ? FG_COLOR : BG_COLOR;
                pix_last_s  = 1'b0;
                state_s     = SHIFT;
            end
            SHIFT: begin
                if (pix_ready) begin
                    if (cnt_r == CNT_LAST) begin
                        shreg_s     = {GLYPH_W{1'b0}};
                        cnt_s       = {CNT_W{1'b0}};
                        pix_valid_s = 1'b0;
                        pix_data_s  = BG_COLOR;
                        pix_last_s  = 1'b0;
                        state_s     = IDLE;
                    end else begin
                        shreg_nx_s  = shift_en_s ? {shreg_r[GLYPH_W-2:0], 1'b0} : shreg_r;
                        shreg_s     = shreg_nx_s;
                        cnt_s       = cnt_r + CNT_ONE;
                        pix_data_s  = shreg_nx_s[GLYPH_W-1] ? FG_COLOR : BG_COLOR;
                        pix_last_s  = (cnt_s == CNT_LAST);
                        state_s     = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s     = IDLE;
                pix_valid_s = 1'b0;
                pix_last_s  = 1'b0;
                pix_data_s  = BG_COLOR;
            end
        endcase
        glyph_ready_s = (state_s == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wait_cnt_r    <= 2'd0;
            row_r         <= 4'd0;
            rom_addr_r    <= 4'd0;
            shreg_r       <= {GLYPH_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            pix_valid_r   <= 1'b0;
            pix_data_r    <= BG_COLOR;
            pix_last_r    <= 1'b0;
            glyph_ready_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            row_r         <= row_s;
            rom_addr_r    <= rom_addr_s;
            shreg_r       <= shreg_s;
            cnt_r         <= cnt_s;
            pix_valid_r   <= pix_valid_s;
            pix_data_r    <= pix_data_s;
            pix_last_r    <= pix_last_s;
            glyph_ready_r <= glyph_ready_s;
        end
    end

    assign glyph_ready = glyph_ready_r;
    assign rom_addr    = rom_addr_r;
    assign pix_valid   = pix_valid_r;
    assign pix_data    = pix_data_r;
    assign pix_last    = pix_last_r;

endmodule

// File: tb/tb_ascii_glyph_serializer.sv
// Scoreboard bench: a driver queues the expected pixel stream per accepted request, a monitor checks it.
module tb_ascii_glyph_serializer;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;
`ifdef ASCII_GLYPH_DOUBLE_WIDTH_EN
    localparam int NPIX = 32;
    localparam int REP  = 2;
`else
    localparam int NPIX = 16;
    localparam int REP  = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         glyph_valid = 1'b0;
    logic         glyph_ready;
    logic [3:0]   glyph_idx = 4'd0;
    logic [3:0]   glyph_row = 4'd0;
    logic [3:0]   rom_addr;
    logic [255:0] rom_data;
    logic         pix_valid;
    logic         pix_ready = 1'b1;
    logic [11:0]  pix_data;
    logic         pix_last;

    typedef struct packed { logic [11:0] d; logic l; } pix_t;
    pix_t exp_q[$];

    logic [255:0] rom [16];
    int   checks = 0, failures = 0;
    int   cyc = 0, acc_cyc = 0, last_hs_cyc = -10, popped = 0;
    int   rdy_mode = 0;
    bit   lat_pend = 0, addr_known = 0, chk_b2b = 0;
    logic [3:0] exp_addr = 4'd0;

    ascii_glyph_serializer dut (
        .clk(clk), .rst_n(rst_n),
        .glyph_valid(glyph_valid), .glyph_ready(glyph_ready),
        .glyph_idx(glyph_idx), .glyph_row(glyph_row),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    // Glyph ROM with one registered cycle of latency.
    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = ~pix_ready;
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each presented pixel with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (addr_known) check("rom_addr_hold", rom_addr, exp_addr);
            if (pix_valid) begin
                check("glyph_ready_busy", glyph_ready, 0);
                if (lat_pend) begin
                    check("first_pix_latency", cyc - acc_cyc, 3);
                    lat_pend = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel actual=%0h required=none", pix_data);
                end else begin
                    check("pix_data", pix_data, exp_q[0].d);
                    check("pix_last", pix_last, exp_q[0].l);
                    if (pix_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                        if (exp_q.size() == 0) last_hs_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] idx, input logic [3:0] row);
        logic [15:0] word;
        int n;
        @(negedge clk);
        glyph_valid = 1'b1;
        glyph_idx   = idx;
        glyph_row   = row;
        n = 0;
        while (!glyph_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!glyph_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=busy required=ready");
            glyph_valid = 1'b0;
            return;
        end
        for (int c = 0; c < 16; c++) word[15-c] = rom[idx][255 - 16*int'(row) - c];
        for (int j = 0; j < NPIX; j++) exp_q.push_back({(word[15 - j/REP] ? FG : BG), (j == NPIX-1)});
        if (chk_b2b) begin
            check("back_to_back_accept", cyc, last_hs_cyc + 1);
            chk_b2b = 0;
        end
        acc_cyc  = cyc;
        lat_pend = 1;
        @(posedge clk);
        exp_addr   = idx;
        addr_known = 1;
        #1 glyph_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n, p0;
        for (int g = 0; g < 16; g++)
            for (int w = 0; w < 8; w++) rom[g][32*w +: 32] = $urandom;
        rom[6][223 -: 16]  = 16'h0180;
        rom[15][239 -: 16] = 16'h07C0;
        rom[0][255 -: 16]  = 16'h0000;

        #12;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_glyph_ready", glyph_ready, 1);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_pix_data", pix_data, BG);
        @(posedge clk);
        #1 rst_n = 1'b1;

        rdy_mode = 0;
        send(4'd6, 4'd2);
        drain();

        rdy_mode = 1;
        send(4'd15, 4'd1);
        drain();

        rdy_mode = 0;
        send(4'd0, 4'd0);
        chk_b2b = 1;
        send(4'd6, 4'd2);
        drain();

        // Abort a row with reset at pixel 7.
        p0 = popped;
        send(4'd14, 4'd3);
        n = 0;
        while (popped < p0 + 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_pixel7", popped - p0, 7);
        #2 rst_n = 1'b0;
        exp_q.delete();
        lat_pend   = 0;
        addr_known = 0;
        #1;
        check("abort_pix_valid", pix_valid, 0);
        check("abort_glyph_ready", glyph_ready, 1);
        check("abort_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_idle_ready", glyph_ready, 1);

        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
